fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, 1-cycle inst SRAM requests, and a
// small {pc, inst} buffer presented to decode over a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h1c000000,
    parameter int unsigned IBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    localparam int unsigned PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ibuf_entry_t;

    ibuf_entry_t ibuf [IBUF_DEPTH];

    logic [31:0]      fetch_pc;
    logic [31:0]      req_pc;
    logic             req_valid;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             issue;
    logic             push;
    logic             pop;
    logic             buf_empty;
    logic [OCC_W-1:0] occupancy;

    // Conservative room check: buffered entries plus the in-flight one must fit.
    assign occupancy = OCC_W'(count) + OCC_W'(req_valid);
    assign issue     = !reset && !br_taken && (occupancy < OCC_W'(IBUF_DEPTH));
    assign push      = req_valid && !br_taken;
    assign buf_empty = (count == '0);
    assign pop       = id_valid && id_ready;

    assign inst_sram_en    = issue;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wdata = 32'b0;

    assign id_valid = !reset && !buf_empty && !br_taken;

    always_comb begin
        id_pc   = 32'b0;
        id_inst = 32'b0;
        if (!reset && !buf_empty) begin
            id_pc   = ibuf[rd_ptr].pc;
            id_inst = ibuf[rd_ptr].inst;
        end
    end

    // PC generation and in-flight request tracking; a redirect wins over issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            req_valid <= 1'b0;
            req_pc    <= 32'b0;
        end else if (br_taken) begin
            fetch_pc  <= br_target & ~32'h3;
            req_valid <= 1'b0;
        end else begin
            req_valid <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
        end
    end

    // Buffer storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ibuf[wr_ptr] <= '{pc: req_pc, inst: inst_sram_rdata};
        end
    end

    // Pointer and occupancy bookkeeping; a redirect empties the buffer.
    always_ff @(posedge clk) begin
        if (reset || br_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ready/redirect/reset traffic,
// checked each cycle against a queue model of issued-but-undelivered fetches.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h1c000000;
    localparam int          D      = 4;
    localparam logic [31:0] KEY    = 32'hA5A5A5A5;

    logic        clk;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    fetch_unit #(.RESET_PC(RST_PC), .IBUF_DEPTH(D)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_inst         (id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: data for a request appears the next cycle; garbage otherwise.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ KEY;
        else              inst_sram_rdata <= $urandom();
    end

    int          total = 0;
    int          bad   = 0;
    logic [31:0] q[$];      // issued, not yet delivered or flushed (oldest first)
    bit          inflight;  // newest element of q was issued last cycle
    logic [31:0] nfpc;      // next address the model expects to be requested
    logic [31:0] dq[$];     // pcs observed on the DUT at handshakes

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int buffered();
        return q.size() - int'(inflight);
    endfunction

    // One clock cycle: check combinational outputs mid-cycle, advance the model, take the edge.
    task automatic step();
        bit exp_valid;
        bit exp_en;
        @(negedge clk);
        if (reset) begin
            chk("rst_en", 32'(inst_sram_en), 32'd0);
            chk("rst_valid", 32'(id_valid), 32'd0);
            chk("rst_pc", id_pc, 32'd0);
            chk("rst_inst", id_inst, 32'd0);
            q.delete();
            inflight = 1'b0;
            nfpc     = RST_PC;
        end else begin
            exp_valid = (buffered() > 0) && !br_taken;
            exp_en    = !br_taken && (q.size() < D);
            chk("en", 32'(inst_sram_en), 32'(exp_en));
            chk("valid", 32'(id_valid), 32'(exp_valid));
            chk("addr", inst_sram_addr, nfpc);
            chk("we", 32'(inst_sram_we), 32'd0);
            chk("wdata", inst_sram_wdata, 32'd0);
            if (buffered() > 0) begin
                chk("id_pc", id_pc, q[0]);
                chk("id_inst", id_inst, q[0] ^ KEY);
            end else begin
                chk("id_pc_empty", id_pc, 32'd0);
                chk("id_inst_empty", id_inst, 32'd0);
            end
            if (br_taken) begin
                q.delete();
                inflight = 1'b0;
                nfpc     = br_target & ~32'h3;
            end else begin
                if (exp_valid && id_ready) begin
                    dq.push_back(id_pc);
                    void'(q.pop_front());
                end
                if (exp_en) begin
                    q.push_back(nfpc);
                    nfpc = nfpc + 32'd4;
                end
                inflight = exp_en;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_seq(input string tag, input logic [31:0] start, input int n);
        logic [31:0] v;
        chk({tag, "_count"}, 32'(dq.size() >= n), 32'd1);
        for (int i = 0; i < n && i < dq.size(); i++) begin
            v = dq[i];
            chk(tag, v, start + 32'(4 * i));
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        br_taken  = 1'b1;
        br_target = tgt;
        step();
        br_taken  = 1'b0;
        br_target = $urandom();
    endtask

    logic [31:0] hold_pc;
    logic [31:0] first_pc;
    int          waited;

    initial begin
        reset     = 1'b1;
        br_taken  = 1'b0;
        br_target = 32'd0;
        id_ready  = 1'b0;
        inflight  = 1'b0;
        nfpc      = RST_PC;
        @(posedge clk);
        #1;
        run(2);

        // Reset release, streaming with decode always ready
        reset    = 1'b0;
        id_ready = 1'b1;
        dq.delete();
        run(2);
        chk("first_latency_none", 32'(dq.size()), 32'd0);
        run(8);
        chk("stream_pops", 32'(dq.size()), 32'd8);
        check_seq("stream_seq", RST_PC, 8);

        // Stall: buffer fills to depth, outputs hold, no requests
        id_ready = 1'b0;
        run(6);
        hold_pc = id_pc;
        run(4);
        chk("stall_hold_pc", id_pc, hold_pc);
        chk("stall_en_off", 32'(inst_sram_en), 32'd0);
        id_ready = 1'b1;
        dq.delete();
        run(12);
        check_seq("drain_seq", hold_pc, 8);

        // Redirect with 3 entries buffered and one request in flight
        id_ready = 1'b0;
        waited   = 0;
        while (!(buffered() == 3 && inflight) && waited < 20) begin
            step();
            waited++;
        end
        chk("fill_wait", 32'(buffered() == 3 && inflight), 32'd1);
        id_ready = 1'b1;
        dq.delete();
        redirect(32'h1c000100);
        run(2);
        chk("redir_latency_none", 32'(dq.size()), 32'd0);
        run(5);
        check_seq("redir_seq", 32'h1c000100, 5);

        // Unaligned target is forced to a word address
        redirect(32'h1c000203);
        chk("unaligned_addr", inst_sram_addr, 32'h1c000200);
        dq.delete();
        run(4);
        check_seq("unaligned_seq", 32'h1c000200, 2);

        // Back-to-back redirects: only the later stream survives
        dq.delete();
        redirect(32'h1c000400);
        redirect(32'h1c000800);
        run(6);
        check_seq("b2b_seq", 32'h1c000800, 4);

        // Address wrap at the top of the address space
        dq.delete();
        redirect(32'hfffffff8);
        run(7);
        check_seq("wrap_seq", 32'hfffffff8, 4);

        // Reset mid-stream with 2 entries buffered
        id_ready = 1'b0;
        redirect(32'h1c001000);
        waited = 0;
        while (buffered() != 2 && waited < 20) begin
            step();
            waited++;
        end
        chk("two_buf_wait", 32'(buffered()), 32'd2);
        reset = 1'b1;
        step();
        reset    = 1'b0;
        id_ready = 1'b1;
        chk("post_rst_valid", 32'(id_valid), 32'd0);
        dq.delete();
        run(3);
        chk("post_rst_pops", 32'(dq.size()), 32'd1);
        first_pc = (dq.size() > 0) ? dq[0] : 32'hx;
        chk("post_rst_pc", first_pc, RST_PC);

        // Random decode backpressure, redirects and occasional reset
        for (int i = 0; i < 3000; i++) begin
            id_ready  = ($urandom_range(0, 3) != 0);
            br_taken  = ($urandom_range(0, 15) == 0);
            br_target = RST_PC + 32'($urandom_range(0, 1023) * 4) + 32'($urandom_range(0, 3));
            reset     = ($urandom_range(0, 199) == 0);
            step();
        end
        reset    = 1'b0;
        br_taken = 1'b0;
        id_ready = 1'b1;
        run(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
